// File: rtl/pong_defs.sv
// Shared Pong definitions: FSM state encodings, bounce bit indices, winner codes,
// default screen geometry and a saturating score increment.
package pong_defs;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam int unsigned BOUNCE_X = 0;
    localparam int unsigned BOUNCE_Y = 1;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_ONE  = 2'b01;
    localparam logic [1:0] WINNER_TWO  = 2'b10;

    localparam int unsigned DEF_SCREEN_W = 640;
    localparam int unsigned DEF_SCREEN_H = 480;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/collision_check.sv
// Combinational 11-bit geometry tests of the ball against goals, walls and both paddles.
// Paddle overlap is purely geometric; direction gating is applied by the caller.
module collision_check
    import pong_defs::*;
#(
    parameter int unsigned SCREEN_W    = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H    = DEF_SCREEN_H,
    parameter int unsigned GOAL_MARGIN = 4
) (
    input  logic [9:0] i_ball_x,
    input  logic [9:0] i_ball_y,
    input  logic [9:0] i_ball_w,
    input  logic [9:0] i_ball_h,
    input  logic [9:0] i_p1_x,
    input  logic [9:0] i_p1_y,
    input  logic [9:0] i_p1_w,
    input  logic [9:0] i_p1_h,
    input  logic [9:0] i_p2_x,
    input  logic [9:0] i_p2_y,
    input  logic [9:0] i_p2_w,
    input  logic [9:0] i_p2_h,
    output logic       o_goal_left,
    output logic       o_goal_right,
    output logic       o_p1_overlap,
    output logic       o_p2_overlap,
    output logic       o_wall
);

    logic [10:0] w_ball_r, w_ball_b;
    logic [10:0] w_p1_r, w_p1_b, w_p2_r, w_p2_b;

    assign w_ball_r = {1'b0, i_ball_x} + {1'b0, i_ball_w};
    assign w_ball_b = {1'b0, i_ball_y} + {1'b0, i_ball_h};
    assign w_p1_r   = {1'b0, i_p1_x} + {1'b0, i_p1_w};
    assign w_p1_b   = {1'b0, i_p1_y} + {1'b0, i_p1_h};
    assign w_p2_r   = {1'b0, i_p2_x} + {1'b0, i_p2_w};
    assign w_p2_b   = {1'b0, i_p2_y} + {1'b0, i_p2_h};

    assign o_goal_left  = {1'b0, i_ball_x} <= 11'(GOAL_MARGIN);
    assign o_goal_right = w_ball_r >= 11'(SCREEN_W - GOAL_MARGIN);

    // X test is inclusive on the paddle's far edge, Y test is strict on both sides.
    assign o_p1_overlap = ({1'b0, i_ball_x} <= w_p1_r) && (w_ball_r > {1'b0, i_p1_x}) &&
                          ({1'b0, i_ball_y} <  w_p1_b) && (w_ball_b > {1'b0, i_p1_y});
    assign o_p2_overlap = ({1'b0, i_ball_x} <= w_p2_r) && (w_ball_r > {1'b0, i_p2_x}) &&
                          ({1'b0, i_ball_y} <  w_p2_b) && (w_ball_b > {1'b0, i_p2_y});

    assign o_wall = (i_ball_y == '0) || (w_ball_b >= 11'(SCREEN_H));

endmodule

// File: rtl/game_controller.sv
// Pong rally/match sequencer: detects tick edges, resolves goals, paddle and wall bounces, keeps score.
// Define GAME_SPEEDUP_EN to add a speed output that ramps every 4 paddle hits within a rally.
module game_controller
    import pong_defs::*;
#(
    parameter int unsigned SCREEN_W    = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H    = DEF_SCREEN_H,
    parameter int unsigned GOAL_MARGIN = 4,
    parameter int unsigned SERVE_TICKS = 120,
    parameter int unsigned POINT_TICKS = 60,
    parameter int unsigned WIN_SCORE   = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] ball_pos_x,
    input  logic [9:0] ball_pos_y,
    input  logic [9:0] ball_size_x,
    input  logic [9:0] ball_size_y,
    input  logic [9:0] paddle_one_pos_x,
    input  logic [9:0] paddle_one_pos_y,
    input  logic [9:0] paddle_one_size_x,
    input  logic [9:0] paddle_one_size_y,
    input  logic [9:0] paddle_two_pos_x,
    input  logic [9:0] paddle_two_pos_y,
    input  logic [9:0] paddle_two_size_x,
    input  logic [9:0] paddle_two_size_y,
    output logic [1:0] bounce,
    output logic       ball_serve,
    output logic       run,
    output logic [3:0] score_one,
    output logic [3:0] score_two,
    output logic [1:0] winner,
`ifdef GAME_SPEEDUP_EN
    output logic [1:0] speed,
`endif
    output logic [2:0] state
);

    localparam int unsigned MAX_TICKS = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
    localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_TICKS - 1);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

    state_t           r_state, w_state_nx;
    logic             r_tick_d, r_tick_edge;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [3:0]       r_score_one, r_score_two, w_score_one_nx, w_score_two_nx;
    logic [1:0]       r_winner, w_winner_nx;
    logic             r_dir_x, w_dir_nx;
    logic [1:0]       r_bounce, w_bounce_nx;
    logic             r_serve, w_serve_nx;

    logic w_goal_left, w_goal_right, w_p1_overlap, w_p2_overlap, w_wall;

    collision_check #(
        .SCREEN_W   (SCREEN_W),
        .SCREEN_H   (SCREEN_H),
        .GOAL_MARGIN(GOAL_MARGIN)
    ) u_collide (
        .i_ball_x    (ball_pos_x),
        .i_ball_y    (ball_pos_y),
        .i_ball_w    (ball_size_x),
        .i_ball_h    (ball_size_y),
        .i_p1_x      (paddle_one_pos_x),
        .i_p1_y      (paddle_one_pos_y),
        .i_p1_w      (paddle_one_size_x),
        .i_p1_h      (paddle_one_size_y),
        .i_p2_x      (paddle_two_pos_x),
        .i_p2_y      (paddle_two_pos_y),
        .i_p2_w      (paddle_two_size_x),
        .i_p2_h      (paddle_two_size_y),
        .o_goal_left (w_goal_left),
        .o_goal_right(w_goal_right),
        .o_p1_overlap(w_p1_overlap),
        .o_p2_overlap(w_p2_overlap),
        .o_wall      (w_wall)
    );

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_score_one_nx = r_score_one;
        w_score_two_nx = r_score_two;
        w_winner_nx    = r_winner;
        w_dir_nx       = r_dir_x;
        w_bounce_nx    = '0;
        w_serve_nx     = 1'b0;
        case (r_state)
            IDLE, GAME_OVER: begin
                if (start) begin
                    w_score_one_nx = '0;
                    w_score_two_nx = '0;
                    w_winner_nx    = WINNER_NONE;
                    w_serve_nx     = 1'b1;
                    w_cnt_nx       = '0;
                    w_state_nx     = SERVE;
                end
            end
            SERVE: begin
                if (r_tick_edge) begin
                    if (r_cnt == SERVE_LAST) begin
                        w_cnt_nx   = '0;
                        w_state_nx = PLAY;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (r_tick_edge) begin
                    // A goal takes priority and suppresses every bounce on this tick.
                    if (w_goal_left) begin
                        w_score_two_nx = sat_inc(r_score_two);
                        w_cnt_nx       = '0;
                        w_state_nx     = POINT;
                    end else if (w_goal_right) begin
                        w_score_one_nx = sat_inc(r_score_one);
                        w_cnt_nx       = '0;
                        w_state_nx     = POINT;
                    end else begin
                        if (r_dir_x && w_p1_overlap) begin
                            w_bounce_nx[BOUNCE_X] = 1'b1;
                            w_dir_nx              = 1'b0;
                        end else if (!r_dir_x && w_p2_overlap) begin
                            w_bounce_nx[BOUNCE_X] = 1'b1;
                            w_dir_nx              = 1'b1;
                        end
                        if (w_wall) begin
                            w_bounce_nx[BOUNCE_Y] = 1'b1;
                        end
                    end
                end
            end
            POINT: begin
                if (r_score_one == WIN) begin
                    w_winner_nx = WINNER_ONE;
                    w_state_nx  = GAME_OVER;
                end else if (r_score_two == WIN) begin
                    w_winner_nx = WINNER_TWO;
                    w_state_nx  = GAME_OVER;
                end else if (r_tick_edge) begin
                    if (r_cnt == POINT_LAST) begin
                        w_cnt_nx   = '0;
                        w_serve_nx = 1'b1;
                        w_dir_nx   = ~r_dir_x;
                        w_state_nx = SERVE;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tick_d    <= 1'b0;
            r_tick_edge <= 1'b0;
            r_cnt       <= '0;
            r_score_one <= '0;
            r_score_two <= '0;
            r_winner    <= WINNER_NONE;
            r_dir_x     <= 1'b0;
            r_bounce    <= '0;
            r_serve     <= 1'b0;
        end else begin
            r_tick_d    <= tick;
            r_tick_edge <= tick & ~r_tick_d;
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_score_one <= w_score_one_nx;
            r_score_two <= w_score_two_nx;
            r_winner    <= w_winner_nx;
            r_dir_x     <= w_dir_nx;
            r_bounce    <= w_bounce_nx;
            r_serve     <= w_serve_nx;
        end
    end

`ifdef GAME_SPEEDUP_EN
    logic [1:0] r_hits, r_speed;

    always_ff @(posedge clk) begin
        if (reset || w_serve_nx) begin
            r_hits  <= '0;
            r_speed <= '0;
        end else if (w_bounce_nx[BOUNCE_X]) begin
            r_hits <= r_hits + 2'd1;
            if (r_hits == 2'd3 && r_speed != 2'd3) begin
                r_speed <= r_speed + 2'd1;
            end
        end
    end

    assign speed = r_speed;
`endif

    assign bounce     = r_bounce;
    assign ball_serve = r_serve;
    assign run        = (r_state == PLAY);
    assign score_one  = r_score_one;
    assign score_two  = r_score_two;
    assign winner     = r_winner;
    assign state      = r_state;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: directed scenarios plus randomized rallies
// checked against a rule-level reference model of the match.
module tb_game_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [1:0] bounce;
    logic       ball_serve, run;
    logic [3:0] score_one, score_two;
    logic [1:0] winner;
    logic [2:0] state;
`ifdef GAME_SPEEDUP_EN
    logic [1:0] speed;
`endif

    int bx = 320, by = 240, bw = 8, bh = 8;
    int p1x = 20, p1y = 190, p1w = 10, p1h = 60;
    int p2x = 610, p2y = 190, p2w = 10, p2h = 60;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: state codes 0 idle,1 serve,2 play,3 point,4 game over.
    int m_state, m_cnt, m_s1, m_s2, m_win, m_dir;
    logic [1:0] obs_bounce;
    logic       obs_serve;

    always #5 clk = ~clk;

    game_controller dut (
        .clk              (clk),
        .reset            (reset),
        .tick             (tick),
        .start            (start),
        .ball_pos_x       (10'(bx)),
        .ball_pos_y       (10'(by)),
        .ball_size_x      (10'(bw)),
        .ball_size_y      (10'(bh)),
        .paddle_one_pos_x (10'(p1x)),
        .paddle_one_pos_y (10'(p1y)),
        .paddle_one_size_x(10'(p1w)),
        .paddle_one_size_y(10'(p1h)),
        .paddle_two_pos_x (10'(p2x)),
        .paddle_two_pos_y (10'(p2y)),
        .paddle_two_size_x(10'(p2w)),
        .paddle_two_size_y(10'(p2h)),
        .bounce           (bounce),
        .ball_serve       (ball_serve),
        .run              (run),
        .score_one        (score_one),
        .score_two        (score_two),
        .winner           (winner),
`ifdef GAME_SPEEDUP_EN
        .speed            (speed),
`endif
        .state            (state)
    );

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0;
    endtask

    task automatic model_start();
        if (m_state == 0 || m_state == 4) begin
            m_s1 = 0; m_s2 = 0; m_win = 0; m_state = 1; m_cnt = 0;
        end
    endtask

    task automatic model_tick(output logic [1:0] eb, output logic es);
        bit hit1, hit2;
        eb = 2'b00;
        es = 1'b0;
        hit1 = (bx <= p1x + p1w) && (bx + bw > p1x) && (by < p1y + p1h) && (by + bh > p1y);
        hit2 = (bx <= p2x + p2w) && (bx + bw > p2x) && (by < p2y + p2h) && (by + bh > p2y);
        case (m_state)
            1: begin
                m_cnt++;
                if (m_cnt == 120) begin m_state = 2; m_cnt = 0; end
            end
            2: begin
                if (bx <= 4) begin
                    m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
                    m_cnt = 0;
                    if (m_s2 == 9) begin m_state = 4; m_win = 2; end else m_state = 3;
                end else if (bx + bw >= 636) begin
                    m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
                    m_cnt = 0;
                    if (m_s1 == 9) begin m_state = 4; m_win = 1; end else m_state = 3;
                end else begin
                    if (m_dir == 1 && hit1) begin eb[0] = 1'b1; m_dir = 0; end
                    else if (m_dir == 0 && hit2) begin eb[0] = 1'b1; m_dir = 1; end
                    if (by == 0 || by + bh >= 480) eb[1] = 1'b1;
                end
            end
            3: begin
                m_cnt++;
                if (m_cnt == 60) begin es = 1'b1; m_dir ^= 1; m_state = 1; m_cnt = 0; end
            end
            default: ;
        endcase
    endtask

    // Drives one tick pulse; bounce/serve sampled the clk they pulse, caller resumes one clk later.
    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk); obs_bounce = bounce; obs_serve = ball_serve;
        @(negedge clk);
    endtask

    task automatic do_start(output int pulses);
        pulses = 0;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (ball_serve === 1'b1) pulses++;
        repeat (3) begin
            @(negedge clk);
            if (ball_serve === 1'b1) pulses++;
        end
    endtask

    task automatic advance_ticks(input int n);
        logic [1:0] eb; logic es;
        for (int i = 0; i < n; i++) begin do_tick(); model_tick(eb, es); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp++; if (state !== 3'd0)      begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_cmp++; if (run !== 1'b0)        begin n_bad++; $display("FAIL reset_run: got %0b expected 0", run); end
        n_cmp++; if (bounce !== 2'b00)    begin n_bad++; $display("FAIL reset_bounce: got %b expected 00", bounce); end
        n_cmp++; if (ball_serve !== 1'b0) begin n_bad++; $display("FAIL reset_serve: got %b expected 0", ball_serve); end
        n_cmp++; if (score_one !== 4'd0 || score_two !== 4'd0)
            begin n_bad++; $display("FAIL reset_scores: got %0d/%0d expected 0/0", score_one, score_two); end
        n_cmp++; if (winner !== 2'b00)    begin n_bad++; $display("FAIL reset_winner: got %b expected 00", winner); end
    endtask

    task automatic test_serve();
        int p; logic [1:0] eb; logic es;
        bx = 320; by = 240;
        do_start(p); model_start();
        n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL serve_pulse: got %0d pulses expected 1", p); end
        n_cmp++; if (state !== 3'(m_state)) begin n_bad++; $display("FAIL serve_state: got %0d expected %0d", state, m_state); end
        for (int i = 0; i < 120; i++) begin
            do_tick(); model_tick(eb, es);
            n_cmp++; if (run !== logic'(m_state == 2))
                begin n_bad++; $display("FAIL serve_run[%0d]: got %b expected %0d", i, run, m_state == 2); end
            n_cmp++; if (state !== 3'(m_state))
                begin n_bad++; $display("FAIL serve_count[%0d]: got %0d expected %0d", i, state, m_state); end
        end
        n_cmp++; if (state !== 3'd2 || run !== 1'b1)
            begin n_bad++; $display("FAIL serve_to_play: got state %0d run %b expected 2 1", state, run); end
    endtask

    task automatic test_paddle();
        logic [1:0] eb; logic es;
        p1x = 20; p1y = 190; p2x = 610; p2y = 190;
        bx = 605; by = 200;
        do_tick(); model_tick(eb, es);
        n_cmp++; if (obs_bounce !== 2'b01) begin n_bad++; $display("FAIL p2_hit: got %b expected 01", obs_bounce); end
        bx = 22; by = 200;
        do_tick(); model_tick(eb, es);
        n_cmp++; if (obs_bounce !== 2'b01) begin n_bad++; $display("FAIL p1_hit: got %b expected 01", obs_bounce); end
        n_cmp++; if (bounce !== 2'b00) begin n_bad++; $display("FAIL p1_hit_width: got %b expected 00", bounce); end
        start = 1'b1;
        do_tick(); model_tick(eb, es);
        start = 1'b0;
        n_cmp++; if (obs_bounce !== 2'b00) begin n_bad++; $display("FAIL p1_repeat: got %b expected 00", obs_bounce); end
        n_cmp++; if (obs_serve !== 1'b0 || state !== 3'd2)
            begin n_bad++; $display("FAIL start_ignored: got serve %b state %0d expected 0 2", obs_serve, state); end
    endtask

    task automatic test_wall();
        logic [1:0] eb; logic es;
        bx = 300; by = 0;
        do_tick(); model_tick(eb, es);
        n_cmp++; if (obs_bounce !== 2'b10) begin n_bad++; $display("FAIL wall_top: got %b expected 10", obs_bounce); end
        by = 472;
        do_tick(); model_tick(eb, es);
        n_cmp++; if (obs_bounce !== 2'b10) begin n_bad++; $display("FAIL wall_bottom: got %b expected 10", obs_bounce); end
        by = 471;
        do_tick(); model_tick(eb, es);
        n_cmp++; if (obs_bounce !== 2'b00) begin n_bad++; $display("FAIL wall_near: got %b expected 00", obs_bounce); end
        bx = 605; by = 200;
        do_tick(); model_tick(eb, es);
        n_cmp++; if (obs_bounce !== 2'b01) begin n_bad++; $display("FAIL p2_hit2: got %b expected 01", obs_bounce); end
        p1y = 0; bx = 22; by = 0;
        do_tick(); model_tick(eb, es);
        n_cmp++; if (obs_bounce !== 2'b11) begin n_bad++; $display("FAIL corner: got %b expected 11", obs_bounce); end
        p1y = 190;
    endtask

    task automatic test_goal();
        logic [1:0] eb; logic es;
        bx = 3; by = 0;
        do_tick(); model_tick(eb, es);
        n_cmp++; if (obs_bounce !== 2'b00) begin n_bad++; $display("FAIL goal_no_bounce: got %b expected 00", obs_bounce); end
        n_cmp++; if (score_two !== 4'd1 || score_one !== 4'd0)
            begin n_bad++; $display("FAIL goal_score: got %0d/%0d expected 0/1", score_one, score_two); end
        n_cmp++; if (run !== 1'b0 || state !== 3'd3)
            begin n_bad++; $display("FAIL goal_state: got run %b state %0d expected 0 3", run, state); end
        bx = 320; by = 240;
        for (int i = 0; i < 60; i++) begin
            do_tick(); model_tick(eb, es);
            n_cmp++; if (obs_serve !== es)
                begin n_bad++; $display("FAIL point_serve[%0d]: got %b expected %b", i, obs_serve, es); end
            n_cmp++; if (state !== 3'(m_state))
                begin n_bad++; $display("FAIL point_state[%0d]: got %0d expected %0d", i, state, m_state); end
        end
        advance_ticks(120);
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL reserve_play: got %0d expected 2", state); end
        bx = 22; by = 200;
        do_tick(); model_tick(eb, es);
        n_cmp++; if (obs_bounce !== 2'b01) begin n_bad++; $display("FAIL dir_toggle: got %b expected 01", obs_bounce); end
    endtask

    task automatic test_game_over();
        int p; logic [1:0] eb; logic es;
        for (int g = 0; g < 9; g++) begin
            bx = 630; by = 200;
            do_tick(); model_tick(eb, es);
            n_cmp++; if (score_one !== 4'(m_s1))
                begin n_bad++; $display("FAIL right_goal[%0d]: got %0d expected %0d", g, score_one, m_s1); end
            bx = 320; by = 240;
            if (m_state == 3) advance_ticks(180);
        end
        n_cmp++; if (state !== 3'd4 || winner !== 2'b01 || score_one !== 4'd9)
            begin n_bad++; $display("FAIL game_over: got state %0d winner %b score %0d expected 4 01 9", state, winner, score_one); end
        repeat (5) @(negedge clk);
        n_cmp++; if (winner !== 2'b01 || run !== 1'b0)
            begin n_bad++; $display("FAIL winner_hold: got winner %b run %b expected 01 0", winner, run); end
        do_start(p); model_start();
        n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL restart_pulse: got %0d expected 1", p); end
        n_cmp++; if (score_one !== 4'd0 || score_two !== 4'd0 || winner !== 2'b00 || state !== 3'd1)
            begin n_bad++; $display("FAIL restart_clear: got %0d/%0d winner %b state %0d", score_one, score_two, winner, state); end
    endtask

    task automatic test_reset_mid_serve();
        int p; logic [1:0] eb; logic es;
        advance_ticks(50);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        n_cmp++; if (state !== 3'd0 || run !== 1'b0 || score_one !== 4'd0 || score_two !== 4'd0)
            begin n_bad++; $display("FAIL midserve_reset: got state %0d run %b scores %0d/%0d", state, run, score_one, score_two); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (ball_serve !== 1'b0 || state !== 3'd0)
            begin n_bad++; $display("FAIL midserve_idle: got serve %b state %0d expected 0 0", ball_serve, state); end
        do_start(p); model_start();
        n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL midserve_start: got %0d expected 1", p); end
        for (int i = 0; i < 120; i++) begin
            do_tick(); model_tick(eb, es);
            n_cmp++; if (state !== 3'(m_state))
                begin n_bad++; $display("FAIL recount[%0d]: got %0d expected %0d", i, state, m_state); end
        end
    endtask

    task automatic test_random();
        int p; logic [1:0] eb; logic es;
        for (int i = 0; i < 900; i++) begin
            if (m_state == 0 || m_state == 4) begin
                do_start(p); model_start();
                n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL rnd_start[%0d]: got %0d expected 1", i, p); end
            end
            p1x = $urandom_range(0, 40);  p1y = $urandom_range(0, 420);
            p1w = $urandom_range(4, 16);  p1h = $urandom_range(20, 80);
            p2x = $urandom_range(580, 620); p2y = $urandom_range(0, 420);
            p2w = $urandom_range(4, 16);  p2h = $urandom_range(20, 80);
            bw = $urandom_range(1, 16);   bh = $urandom_range(1, 16);
            case ($urandom_range(0, 99))
                0:       bx = $urandom_range(0, 4);
                1:       bx = 636 - bw + $urandom_range(0, 3);
                2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 32, 33, 34, 35, 36, 37, 38, 39, 40:
                         bx = $urandom_range(5, p1x + p1w + 2);
                41, 42, 43, 44, 45, 46, 47, 48, 49, 50, 51, 52, 53, 54, 55, 56, 57, 58, 59, 60, 61, 62, 63, 64, 65, 66, 67, 68, 69, 70, 71, 72, 73, 74, 75, 76, 77, 78, 79:
                         bx = $urandom_range(p2x - bw - 2, 636 - bw - 1);
                default: bx = $urandom_range(5, 620 - bw);
            endcase
            case ($urandom_range(0, 9))
                0:       by = 0;
                1:       by = 480 - bh + $urandom_range(0, 2);
                default: by = $urandom_range(0, 479 - bh);
            endcase
            do_tick(); model_tick(eb, es);
            n_cmp++; if (obs_bounce !== eb)
                begin n_bad++; $display("FAIL rnd_bounce[%0d]: got %b expected %b", i, obs_bounce, eb); end
            n_cmp++; if (obs_serve !== es)
                begin n_bad++; $display("FAIL rnd_serve[%0d]: got %b expected %b", i, obs_serve, es); end
            n_cmp++; if (state !== 3'(m_state))
                begin n_bad++; $display("FAIL rnd_state[%0d]: got %0d expected %0d", i, state, m_state); end
            n_cmp++; if (score_one !== 4'(m_s1) || score_two !== 4'(m_s2) || winner !== 2'(m_win))
                begin n_bad++; $display("FAIL rnd_score[%0d]: got %0d/%0d/%b expected %0d/%0d/%0d", i, score_one, score_two, winner, m_s1, m_s2, m_win); end
        end
    endtask

    task automatic test_reset_mid_point();
        int p;
        if (m_state == 0 || m_state == 4) begin do_start(p); model_start(); end
        for (int i = 0; i < 400 && m_state != 2; i++) advance_ticks(1);
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL midpoint_play: got %0d expected 2", state); end
        bw = 8; bh = 8; bx = 2; by = 200;
        advance_ticks(1);
        bx = 320; by = 240;
        advance_ticks(10);
        n_cmp++; if (score_two === 4'd0) begin n_bad++; $display("FAIL midpoint_scored: got %0d expected nonzero", score_two); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_cmp++; if (state !== 3'd0 || score_one !== 4'd0 || score_two !== 4'd0 || winner !== 2'b00)
            begin n_bad++; $display("FAIL midpoint_reset: got state %0d scores %0d/%0d winner %b", state, score_one, score_two, winner); end
        repeat (3) begin
            @(negedge clk);
            n_cmp++; if (ball_serve !== 1'b0 || state !== 3'd0)
                begin n_bad++; $display("FAIL midpoint_quiet: got serve %b state %0d expected 0 0", ball_serve, state); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_serve();
        test_paddle();
        test_wall();
        test_goal();
        test_game_over();
        test_reset_mid_serve();
        test_random();
        test_reset_mid_point();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
